// File: rtl/rv_pkg.sv
// Shared RV32 memory-stage definitions: funct3 load/store codes
// and the memory access FSM state encoding.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a bus word and
// sign- or zero-extends it to the register width.
module load_extend
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            F3_H:    data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns store lanes, runs a word bus
// handshake and stalls the pipeline until the access completes.
module mem_access_unit
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [DATA_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    input  logic [FUNCT3_WIDTH-1:0] funct3M,
    output logic                    StallM,
    output logic [DATA_WIDTH-1:0]   ReadDataM,
    output logic                    AccessErrM,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    state_t state, state_next;

    logic [2:0]            f3;
    logic [1:0]            off;
    logic                  access;
    logic                  pending;
    logic                  legal;
    logic                  go;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] load_data;

    assign f3      = funct3M[2:0];
    assign off     = ALUResultM[1:0];
    assign access  = MemReadM | MemWriteM;
    assign pending = access & (state == IDLE);
    assign go      = pending & legal;

    // Store wins over load when both are requested.
    always_comb begin
        legal      = 1'b0;
        be_next    = 4'b1111;
        wdata_next = '0;
        if (MemWriteM) begin
            case (f3)
                F3_B: begin
                    legal      = 1'b1;
                    be_next    = 4'b0001 << off;
                    wdata_next = {(DATA_WIDTH/8){WriteDataM[7:0]}};
                end
                F3_H: begin
                    legal      = ~off[0];
                    be_next    = 4'b0011 << off;
                    wdata_next = {(DATA_WIDTH/16){WriteDataM[15:0]}};
                end
                F3_W: begin
                    legal      = (off == 2'b00);
                    wdata_next = WriteDataM;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: legal = 1'b1;
                F3_H, F3_HU: legal = ~off[0];
                F3_W:        legal = (off == 2'b00);
                default:     legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (go) state_next = BUSY;
            BUSY:    if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign StallM     = RST_N & ((state == BUSY) | go);
    assign AccessErrM = RST_N & pending & ~legal;
    assign mem_req    = (state == BUSY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            ReadDataM <= '0;
        end else begin
            state <= state_next;
            if (go) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                mem_be    <= be_next;
                mem_wdata <= wdata_next;
                off_q     <= off;
                f3_q      <= f3;
            end
            if ((state == BUSY) && mem_ack && !mem_we) begin
                ReadDataM <= load_data;
            end
        end
    end

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, illegal
// accesses, delayed acks and reset in the middle of a transfer.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        AccessErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .AccessErrM (AccessErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Results of the last access run by do_access.
    int          stalls;
    int          reqs;
    logic        stable;
    logic        timed_out;
    logic [31:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata;
    logic        b_we;

    // Called just after a rising edge; presents one access and acks it
    // on the (delay+1)-th BUSY cycle, then retires it after DONE.
    task automatic do_access(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int delay, input logic [31:0] rd);
        MemWriteM  = wr;
        MemReadM   = ~wr;
        ALUResultM = addr;
        WriteDataM = wd;
        funct3M    = f3;
        mem_rdata  = rd;
        mem_ack    = 1'b0;
        stalls     = 0;
        reqs       = 0;
        stable     = 1'b1;
        timed_out  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (StallM) stalls++;
            if (mem_req) begin
                if (reqs == 0) begin
                    b_addr  = mem_addr;
                    b_be    = mem_be;
                    b_wdata = mem_wdata;
                    b_we    = mem_we;
                end else if (mem_addr !== b_addr || mem_be !== b_be ||
                             mem_wdata !== b_wdata || mem_we !== b_we) begin
                    stable = 1'b0;
                end
                reqs++;
            end
            mem_ack = mem_req && (reqs == delay + 1);
            if (!StallM) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge CLK);
        #1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        mem_ack   = 1'b0;
        check("timeout", {31'd0, timed_out}, 32'd0);
    endtask

    initial begin
        RST_N      = 1'b0;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0000_0100;
        WriteDataM = 32'h0;
        funct3M    = 3'b010;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        #3;
        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_err", {31'd0, AccessErrM}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_be", {28'd0, mem_be}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Stray ack while idle must be ignored.
        @(posedge CLK);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
        check("idle_ack_rdata", ReadDataM, 32'h0);

        // SW 0x104
        do_access(1'b1, 32'h104, 32'hDEAD_BEEF, 3'b010, 0, 32'h0);
        check("sw_addr", b_addr, 32'h104);
        check("sw_be", {28'd0, b_be}, 32'hF);
        check("sw_wdata", b_wdata, 32'hDEAD_BEEF);
        check("sw_we", {31'd0, b_we}, 32'd1);
        check("sw_stall", stalls, 2);
        check("sw_reqs", reqs, 1);

        // LB 0x203 then LBU, back to back
        do_access(1'b0, 32'h203, 32'h0, 3'b000, 0, 32'h80FF_1234);
        check("lb_data", ReadDataM, 32'hFFFF_FF80);
        check("lb_addr", b_addr, 32'h200);
        check("lb_be", {28'd0, b_be}, 32'hF);
        check("lb_we", {31'd0, b_we}, 32'd0);
        do_access(1'b0, 32'h203, 32'h0, 3'b100, 0, 32'h80FF_1234);
        check("lbu_data", ReadDataM, 32'h0000_0080);
        check("lbu_stall", stalls, 2);

        // SH 0x2: store leaves ReadDataM alone
        do_access(1'b1, 32'h2, 32'h0000_ABCD, 3'b001, 0, 32'hFFFF_FFFF);
        check("sh_be", {28'd0, b_be}, 32'hC);
        check("sh_wdata", b_wdata, 32'hABCD_ABCD);
        check("sh_addr", b_addr, 32'h0);
        check("sh_keep", ReadDataM, 32'h0000_0080);

        // SB at offset 1, LHU at offset 2, LW
        do_access(1'b1, 32'h31, 32'h0000_005A, 3'b000, 0, 32'h0);
        check("sb_be", {28'd0, b_be}, 32'h2);
        check("sb_wdata", b_wdata, 32'h5A5A_5A5A);
        do_access(1'b0, 32'h42, 32'h0, 3'b101, 0, 32'hF00D_0001);
        check("lhu_data", ReadDataM, 32'h0000_F00D);
        do_access(1'b0, 32'h48, 32'h0, 3'b010, 0, 32'hCAFE_1234);
        check("lw_data", ReadDataM, 32'hCAFE_1234);

        // Misaligned LW 0x101
        MemReadM   = 1'b1;
        ALUResultM = 32'h101;
        funct3M    = 3'b010;
        @(negedge CLK);
        check("mis_err", {31'd0, AccessErrM}, 32'd1);
        check("mis_stall", {31'd0, StallM}, 32'd0);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        @(posedge CLK);
        #1;
        MemReadM = 1'b0;
        @(negedge CLK);
        check("mis_err_end", {31'd0, AccessErrM}, 32'd0);
        check("mis_req_end", {31'd0, mem_req}, 32'd0);

        // Store with a load-only funct3 is illegal
        @(posedge CLK);
        #1;
        MemWriteM  = 1'b1;
        ALUResultM = 32'h40;
        funct3M    = 3'b100;
        @(negedge CLK);
        check("bad_f3_err", {31'd0, AccessErrM}, 32'd1);
        check("bad_f3_stall", {31'd0, StallM}, 32'd0);
        @(posedge CLK);
        #1;
        MemWriteM = 1'b0;
        @(negedge CLK);
        check("bad_f3_req", {31'd0, mem_req}, 32'd0);
        @(posedge CLK);
        #1;

        // LH with ack delayed 4 cycles
        do_access(1'b0, 32'h6, 32'h0, 3'b001, 4, 32'h8765_0000);
        check("lh_reqs", reqs, 5);
        check("lh_stall", stalls, 6);
        check("lh_stable", {31'd0, stable}, 32'd1);
        check("lh_data", ReadDataM, 32'hFFFF_8765);

        // Reset during BUSY
        MemReadM   = 1'b1;
        ALUResultM = 32'h10;
        funct3M    = 3'b001;
        mem_ack    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("mid_req_busy", {31'd0, mem_req}, 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_req_drop", {31'd0, mem_req}, 32'd0);
        check("mid_stall", {31'd0, StallM}, 32'd0);
        check("mid_rdata", ReadDataM, 32'h0);
        MemReadM = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_stall", {31'd0, StallM}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
